i2s_apb_sequencer: RTL
======================

// Module: i2s_apb_sequencer
// PURPOSE
//  APB requester that drives one I2S_top pair (TX instance + RX instance) over the shared register bus.
//  Programs both control words, preloads the TxFIFO, arms the receiver, then streams words from a
//  valid/ready source into TXDATA and drains RXDATA into a valid/ready sink until told to stop.
//  Sits between a sample producer/consumer and the I2S register bus; it is the hardware form of the
//  bus-side sequence used to bring up a link.
// PARAMETERS
//  TX_BASE     32'h00  base address of transmitting I2S_top
//  RX_BASE     32'h20  base address of receiving I2S_top
//  CTRL_OFS    32'h00  control word offset
//  STAT_OFS    32'h04  status/flags offset (13-bit flags in prdata[12:0])
//  TXD_OFS     32'h08  TxFIFO write offset
//  RXD_OFS     32'h12  RxFIFO read offset (RX_BASE+RXD_OFS = 32'h32)
//  TXFULL_BIT  0       flags bit: TxFIFO full
//  RXEMPTY_BIT 1       flags bit: RxFIFO empty
//  STOP_BIT    2       position of 'stop' in the control word
//  PRELOAD     15      words written to TxFIFO before arming the receiver (1..255)
// PORTS
//  pclk       in   1   bus clock; single clock domain
//  preset     in   1   asynchronous, active-high reset
//  start      in   1   1-cycle pulse, accepted only in IDLE
//  stop_req   in   1   level/pulse, sampled in PRELOAD/ARM/RUN
//  cfg_tx     in   32  control word for TX instance
//  cfg_rx     in   32  control word for RX instance (stop bit overridden by block)
//  src_data   in   32  sample to transmit
//  src_valid  in   1   src_data valid
//  src_ready  out  1   1-cycle pulse: src_data consumed
//  snk_data   out  32  received sample
//  snk_valid  out  1   held until snk_ready
//  snk_ready  in   1   sink accepts snk_data
//  penable    out  1   APB access phase
//  pwrite     out  1   1=write, 0=read
//  paddr      out  32  APB address
//  pwdata     out  32  APB write data
//  prdata     in   32  APB read data
//  busy       out  1   high in any state except IDLE
//  tx_count   out  16  words written to TXDATA since start (wraps)
//  rx_count   out  16  words read from RXDATA since start (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-transfer drops penable immediately, no completion.
//  Transfer: fixed 2 cycles, no wait states. SETUP: paddr/pwrite/pwdata valid, penable=0.
//   ACCESS: penable=1, signals held. prdata captured on the edge ending ACCESS.
//   Back-to-back transfers allowed; penable returns to 0 for each SETUP.
//  FSM: IDLE -start-> CFG_TX (write cfg_tx @TX_BASE+CTRL_OFS)
//   -> CFG_RX (write cfg_rx with STOP_BIT=1 @RX_BASE+CTRL_OFS)
//   -> PRELOAD: loop {read TX STAT; if !TXFULL & src_valid write TXDATA} until PRELOAD words written
//   -> ARM (write cfg_rx with STOP_BIT=0) -> RUN.
//   RUN: alternate TX slot then RX slot, each starts with a STAT read of its instance.
//    TX slot: write TXDATA only if !TXFULL and src_valid; else skip.
//    RX slot: read RXDATA only if !RXEMPTY and !snk_valid; else skip.
//   stop_req seen -> finish transfer in flight -> HALT (write cfg_rx with STOP_BIT=1) -> IDLE.
//   stop_req during CFG_TX/CFG_RX: ignored until PRELOAD. start outside IDLE: ignored.
//  src_ready pulses in the ACCESS cycle of a TXDATA write; pwdata = src_data latched at SETUP.
//  snk_data/snk_valid set on the edge ending a RXDATA ACCESS.
//   snk_valid clears on snk_valid&snk_ready; snk_data holds value until next read.
//  Counters increment at TXDATA/RXDATA ACCESS completion; clear on start; wrap FFFF->0000.
//  src_valid dropping after SETUP of a TXDATA write does not abort it (word already latched).
// TESTING
//  1 start, cfg_tx=32'h4D0C1 -> first writes: @00 data 4D0C1, @20 cfg_rx|4, 2 cycles each, penable 0,1.
//  2 src_valid=1, flags=0 -> exactly 15 TXDATA writes @08, then @20 write cfg_rx&~4, tx_count=15.
//  3 RUN, RX flags !empty, prdata=32'hCAFEF00D, snk_ready=0 -> snk_valid held, no further RXDATA
//    reads; snk_ready=1 -> rx_count+1.
//  4 TX flags TXFULL=1 for 10 cycles -> no TXDATA write, src_ready stays 0; resumes on clear.
//  5 stop_req mid-ACCESS -> transfer completes, next transfer is write @20 with STOP_BIT=1, busy falls.
//  6 preset asserted during ACCESS -> penable=0 same cycle, FSM IDLE, counters 0; start restarts at CFG_TX.

Source files
------------

// File: rtl/i2s_apb_sequencer.sv
// APB requester that brings up an I2S TX/RX pair: programs both control words, preloads the
// TxFIFO, arms the receiver, then streams a valid/ready source into TXDATA and RXDATA into a sink.
module i2s_apb_sequencer #(
    parameter logic [31:0] TX_BASE     = 32'h00,
    parameter logic [31:0] RX_BASE     = 32'h20,
    parameter logic [31:0] CTRL_OFS    = 32'h00,
    parameter logic [31:0] STAT_OFS    = 32'h04,
    parameter logic [31:0] TXD_OFS     = 32'h08,
    parameter logic [31:0] RXD_OFS     = 32'h12,
    parameter int          TXFULL_BIT  = 0,
    parameter int          RXEMPTY_BIT = 1,
    parameter int          STOP_BIT    = 2,
    parameter int          PRELOAD     = 15
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        start,
    input  logic        stop_req,
    input  logic [31:0] cfg_tx,
    input  logic [31:0] cfg_rx,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] snk_data,
    output logic        snk_valid,
    input  logic        snk_ready,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);

    localparam logic [31:0] STOP_MASK    = 32'd1 << STOP_BIT;
    localparam logic [15:0] PRELOAD_LAST = 16'(PRELOAD - 1);

    // Each non-IDLE state names the APB transfer currently on the bus.
    typedef enum logic [3:0] {
        S_IDLE, S_CFG_TX, S_CFG_RX, S_PRE_STAT, S_PRE_DATA, S_ARM,
        S_TX_STAT, S_TX_DATA, S_RX_STAT, S_RX_DATA, S_HALT
    } state_t;

    state_t      state_q, state_d, setup_state;
    logic        penable_q, pwrite_q, src_ready_q, snk_valid_q, busy_q, stop_q;
    logic [31:0] paddr_q, pwdata_q, snk_data_q;
    logic [15:0] tx_count_q, rx_count_q;
    logic        sampling, stop_now;
    logic [31:0] addr_d, wdata_d;
    logic        write_d;

    assign sampling = (state_q == S_PRE_STAT) || (state_q == S_PRE_DATA) || (state_q == S_ARM) ||
                      (state_q == S_TX_STAT)  || (state_q == S_TX_DATA)  ||
                      (state_q == S_RX_STAT)  || (state_q == S_RX_DATA);
    assign stop_now = stop_q | stop_req;

    // Transfer that follows the one currently in its ACCESS phase.
    always_comb begin
        state_d = state_q;
        if (sampling && stop_now) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_CFG_TX:   state_d = S_CFG_RX;
                S_CFG_RX:   state_d = S_PRE_STAT;
                S_PRE_STAT: state_d = (!prdata[TXFULL_BIT] && src_valid) ? S_PRE_DATA : S_PRE_STAT;
                S_PRE_DATA: state_d = (tx_count_q == PRELOAD_LAST) ? S_ARM : S_PRE_STAT;
                S_ARM:      state_d = S_TX_STAT;
                S_TX_STAT:  state_d = (!prdata[TXFULL_BIT] && src_valid) ? S_TX_DATA : S_RX_STAT;
                S_TX_DATA:  state_d = S_RX_STAT;
                S_RX_STAT:  state_d = (!prdata[RXEMPTY_BIT] && !snk_valid_q) ? S_RX_DATA : S_TX_STAT;
                S_RX_DATA:  state_d = S_TX_STAT;
                S_HALT:     state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    // SETUP-phase address/data for whichever transfer is about to begin.
    assign setup_state = (state_q == S_IDLE) ? S_CFG_TX : state_d;

    always_comb begin
        addr_d  = 32'd0;
        write_d = 1'b0;
        wdata_d = 32'd0;
        case (setup_state)
            S_CFG_TX: begin
                addr_d = TX_BASE + CTRL_OFS; write_d = 1'b1; wdata_d = cfg_tx;
            end
            S_CFG_RX, S_HALT: begin
                addr_d = RX_BASE + CTRL_OFS; write_d = 1'b1; wdata_d = cfg_rx | STOP_MASK;
            end
            S_ARM: begin
                addr_d = RX_BASE + CTRL_OFS; write_d = 1'b1; wdata_d = cfg_rx & ~STOP_MASK;
            end
            S_PRE_STAT, S_TX_STAT: addr_d = TX_BASE + STAT_OFS;
            S_RX_STAT:             addr_d = RX_BASE + STAT_OFS;
            S_PRE_DATA, S_TX_DATA: begin
                addr_d = TX_BASE + TXD_OFS; write_d = 1'b1; wdata_d = src_data;
            end
            S_RX_DATA:             addr_d = RX_BASE + RXD_OFS;
            default: ;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= S_IDLE;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            src_ready_q <= 1'b0;
            snk_valid_q <= 1'b0;
            snk_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            stop_q      <= 1'b0;
            tx_count_q  <= 16'd0;
            rx_count_q  <= 16'd0;
        end else begin
            src_ready_q <= 1'b0;
            if (snk_valid_q && snk_ready) begin
                snk_valid_q <= 1'b0;
            end
            if (sampling && stop_req) begin
                stop_q <= 1'b1;
            end

            if (state_q == S_IDLE) begin
                if (start) begin
                    state_q    <= S_CFG_TX;
                    busy_q     <= 1'b1;
                    tx_count_q <= 16'd0;
                    rx_count_q <= 16'd0;
                    penable_q  <= 1'b0;
                    paddr_q    <= addr_d;
                    pwrite_q   <= write_d;
                    pwdata_q   <= wdata_d;
                end
            end else if (!penable_q) begin
                penable_q   <= 1'b1;
                src_ready_q <= (state_q == S_PRE_DATA) || (state_q == S_TX_DATA);
            end else begin
                // End of ACCESS: retire this transfer and launch the next SETUP.
                penable_q <= 1'b0;
                if ((state_q == S_PRE_DATA) || (state_q == S_TX_DATA)) begin
                    tx_count_q <= tx_count_q + 16'd1;
                end
                if (state_q == S_RX_DATA) begin
                    rx_count_q  <= rx_count_q + 16'd1;
                    snk_data_q  <= prdata;
                    snk_valid_q <= 1'b1;
                end
                if (state_d == S_HALT) begin
                    stop_q <= 1'b0;
                end
                state_q <= state_d;
                if (state_d == S_IDLE) begin
                    busy_q   <= 1'b0;
                    pwrite_q <= 1'b0;
                end else begin
                    paddr_q  <= addr_d;
                    pwrite_q <= write_d;
                    pwdata_q <= wdata_d;
                end
            end
        end
    end

    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign src_ready = src_ready_q;
    assign snk_valid = snk_valid_q;
    assign snk_data  = snk_data_q;
    assign busy      = busy_q;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;

endmodule
